// File: rtl/pipe_pkg.sv
// Write-back bus layout shared by the WB stage and the register-file write-port arbiter.
// A write-back slice is {data, addr, we}, with we in bit 0.
package pipe_pkg;

    localparam int unsigned WB_DATA_W = 32;
    localparam int unsigned WB_ADDR_W = 5;

    localparam int unsigned WE_BIT    = 0;
    localparam int unsigned ADDR_LSB  = 1;
    localparam int unsigned DATA_LSB  = WB_ADDR_W + 1;
    localparam int unsigned WB_BUS_W  = WB_DATA_W + WB_ADDR_W + 1;

    function automatic int unsigned wb_bus_w(input int unsigned dw, input int unsigned aw);
        return dw + aw + 1;
    endfunction

    function automatic int unsigned data_lsb(input int unsigned aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/rf_wport_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr, wrapping.
// Also intended for use by the memory-port arbiter.
module rr_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] idx,
    output logic          any
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] masked;

    // The lower copy is masked below ptr and the upper copy is left whole, so a
    // lowest-index search over 2N bits wraps without any modulo logic.
    always_comb begin
        dbl    = {req, req};
        masked = '0;
        for (int unsigned b = 0; b < 2 * N; b++) begin
            masked[b] = dbl[b] && ((b >= N) || (b >= 32'(ptr)));
        end
    end

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int unsigned b = 0; b < 2 * N; b++) begin
            if (masked[b] && !any) begin
                any            = 1'b1;
                idx            = SW'(b % N);
                grant[b % N]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Round-robin arbiter that shares the register-file write port among NUM_REQ
// write-back sources through a one-entry output register.
module rf_wport_arbiter
    import pipe_pkg::*;
#(
    parameter int unsigned  NUM_REQ    = 2,
    parameter int unsigned  ADDR_WIDTH = 5,
    parameter int unsigned  DATA_WIDTH = 32,
    parameter bit           DROP_X0    = 1'b1,
    localparam int unsigned SRC_W      = $clog2(NUM_REQ),
    localparam int unsigned BUS_W      = DATA_WIDTH + ADDR_WIDTH + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ*BUS_W-1:0] req_bus,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [BUS_W-1:0]         rf_bus,
    output logic                     rf_valid,
    input  logic                     rf_ready,
    output logic [SRC_W-1:0]         rf_src,
    output logic                     rf_commit
);

    logic               out_valid_q, out_valid_d;
    logic [BUS_W-1:0]   rf_bus_q, rf_bus_d;
    logic [SRC_W-1:0]   rf_src_q, rf_src_d;
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0] grant;
    logic [SRC_W-1:0]   g_idx;
    logic               g_any;
    logic               slot_free;
    logic               accept;
    logic               keep;
    logic [BUS_W-1:0]   g_slice;

    rr_pick #(
        .N  (NUM_REQ),
        .SW (SRC_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .idx   (g_idx),
        .any   (g_any)
    );

    // Gating with rst keeps req_ready low for the whole reset, not just after the next edge.
    always_comb begin
        slot_free = ~out_valid_q | rf_ready;
        req_ready = (rst && slot_free) ? grant : '0;
        accept    = rst & slot_free & g_any;
        g_slice   = req_bus[int'(g_idx) * BUS_W +: BUS_W];
        keep      = !(DROP_X0 && (!g_slice[WE_BIT] || (g_slice[ADDR_LSB +: ADDR_WIDTH] == '0)));
    end

    always_comb begin
        out_valid_d = out_valid_q;
        rf_bus_d    = rf_bus_q;
        rf_src_d    = rf_src_q;
        rr_ptr_d    = rr_ptr_q;
        if (accept) begin
            rf_bus_d    = g_slice;
            rf_src_d    = g_idx;
            rr_ptr_d    = (32'(g_idx) == NUM_REQ - 1) ? '0 : g_idx + SRC_W'(1);
            out_valid_d = keep;
        end else if (out_valid_q && rf_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            rf_bus_q    <= '0;
            rf_src_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            rf_bus_q    <= rf_bus_d;
            rf_src_q    <= rf_src_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    always_comb begin
        rf_bus    = rf_bus_q;
        rf_valid  = out_valid_q;
        rf_src    = rf_src_q;
        rf_commit = out_valid_q & rf_ready;
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench for rf_wport_arbiter: directed scenarios and random traffic
// compared against a behavioural model of the write-port arbiter.
module tb_rf_wport_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int W  = DW + AW + 1;
    localparam int SW = $clog2(N);

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] req_bus;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   rf_bus;
    logic           rf_valid;
    logic           rf_ready;
    logic [SW-1:0]  rf_src;
    logic           rf_commit;

    always #5 clk = ~clk;

    rf_wport_arbiter #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DROP_X0    (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_bus   (req_bus),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .rf_bus    (rf_bus),
        .rf_valid  (rf_valid),
        .rf_ready  (rf_ready),
        .rf_src    (rf_src),
        .rf_commit (rf_commit)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model state: next source to favour, and the single pending register-file write.
    int           m_ptr;
    bit           m_valid;
    logic [W-1:0] m_bus;
    int           m_src;

    logic [N-1:0] o_ready;
    logic         o_valid;
    logic [W-1:0] o_bus;
    logic [SW-1:0] o_src;
    logic         o_commit;

    function automatic logic [W-1:0] mk(input logic [31:0] d, input logic [4:0] a, input logic we);
        return {d, a, we};
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 0;
        m_bus   = '0;
        m_src   = 0;
    endtask

    // One cycle: drive inputs after the falling edge, check outputs, advance the model to the next rising edge.
    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] bus, input logic rdy);
        int           g;
        logic [N-1:0] exp_rdy;
        bit           sf;
        logic [W-1:0] s;
        @(negedge clk);
        req_valid = v;
        req_bus   = bus;
        rf_ready  = rdy;
        #1;
        o_ready  = req_ready;
        o_valid  = rf_valid;
        o_bus    = rf_bus;
        o_src    = rf_src;
        o_commit = rf_commit;

        sf = !m_valid || rdy;
        g  = -1;
        for (int k = 0; k < N; k++) begin
            int idx = (m_ptr + k) % N;
            if (g < 0 && v[idx]) g = idx;
        end
        exp_rdy = '0;
        if (sf && g >= 0) exp_rdy[g] = 1'b1;

        chk("req_ready", o_ready, exp_rdy);
        chk("onehot0", $onehot0(o_ready), 1);
        chk("rf_valid", o_valid, m_valid);
        chk("rf_commit", o_commit, m_valid && rdy);
        if (m_valid) begin
            chk("rf_bus", o_bus, m_bus);
            chk("rf_src", o_src, m_src);
        end

        if (sf && g >= 0) begin
            s       = bus[g*W +: W];
            m_bus   = s;
            m_src   = g;
            m_ptr   = (g + 1) % N;
            m_valid = s[0] && (s[AW:1] != 0);
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
    endtask

    logic [N*W-1:0] b;

    initial begin
        rst       = 1'b0;
        req_valid = '1;
        req_bus   = '0;
        rf_ready  = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", rf_valid, 0);
        chk("rst_commit", rf_commit, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_bus", rf_bus, 0);
        chk("rst_src", rf_src, 0);
        req_valid = '0;
        rst       = 1'b1;

        // single source
        b = '0;
        b[0*W +: W] = mk(32'hDEADBEEF, 5'd5, 1'b1);
        step(3'b001, b, 1'b1);
        chk("t1_ready", o_ready, 3'b001);
        step(3'b000, b, 1'b1);
        chk("t1_valid", o_valid, 1);
        chk("t1_bus", o_bus, {32'hDEADBEEF, 5'd5, 1'b1});
        chk("t1_src", o_src, 0);
        chk("t1_commit", o_commit, 1);

        // contention, rr_ptr is 1 after the first grant
        b[0*W +: W] = mk(32'h000000A0, 5'd1, 1'b1);
        b[1*W +: W] = mk(32'h000000B1, 5'd2, 1'b1);
        step(3'b011, b, 1'b1); chk("t2_g0", o_ready, 3'b010);
        step(3'b011, b, 1'b1); chk("t2_g1", o_ready, 3'b001);
        step(3'b011, b, 1'b1); chk("t2_g2", o_ready, 3'b010); chk("t2_c2", o_commit, 1);
        step(3'b011, b, 1'b1); chk("t2_g3", o_ready, 3'b001); chk("t2_c3", o_commit, 1);
        step(3'b000, b, 1'b1); chk("t2_c4", o_commit, 1);

        // backpressure
        step(3'b001, b, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(3'b010, b, 1'b0);
            chk("t3_ready", o_ready, 3'b000);
            chk("t3_src", o_src, 0);
            chk("t3_bus", o_bus, {32'h000000A0, 5'd1, 1'b1});
        end
        step(3'b010, b, 1'b1);
        chk("t3_commit", o_commit, 1);
        chk("t3_accept", o_ready, 3'b010);
        step(3'b000, b, 1'b1);

        // x0 / we=0 drop
        b[0*W +: W] = mk(32'h00001234, 5'd0, 1'b1);
        b[1*W +: W] = mk(32'h00000055, 5'd3, 1'b0);
        step(3'b001, b, 1'b1); chk("t4_r0", o_ready, 3'b001);
        step(3'b010, b, 1'b1); chk("t4_r1", o_ready, 3'b010); chk("t4_v0", o_valid, 0);
        step(3'b000, b, 1'b1); chk("t4_v1", o_valid, 0); chk("t4_c", o_commit, 0);

        // wrap on a non power-of-2 requester count
        b[0*W +: W] = mk(32'h00000011, 5'd4, 1'b1);
        b[2*W +: W] = mk(32'h00000077, 5'd9, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(3'b100, b, 1'b1);
            chk("t5_only2", o_ready, 3'b100);
        end
        step(3'b101, b, 1'b1); chk("t5_wrap", o_ready, 3'b001);
        step(3'b000, b, 1'b1);

        // async reset mid-transfer
        step(3'b010, b, 1'b1);
        b[1*W +: W] = mk(32'h00000099, 5'd7, 1'b1);
        step(3'b010, b, 1'b1);
        step(3'b000, b, 1'b0);
        chk("t6_pre", o_valid, 1);
        rst       = 1'b0;
        req_valid = 3'b111;
        #1;
        chk("t6_valid", rf_valid, 0);
        chk("t6_ready", req_ready, 0);
        chk("t6_commit", rf_commit, 0);
        model_reset();
        req_valid = '0;
        #1;
        rst = 1'b1;
        step(3'b111, b, 1'b1);
        chk("t6_first", o_ready, 3'b001);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            logic [N*W-1:0] rb;
            for (int s = 0; s < N; s++) begin
                logic [4:0] a;
                a = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
                rb[s*W +: W] = mk($urandom, a, $urandom_range(0, 4) != 0);
            end
            step(N'($urandom), rb, $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
